// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the Wishbone UART receiver: register offsets, STATUS
// bit positions, receive FSM state encoding and frame length.
// Optional feature macro: WB_UART_RX_PARITY_EN (adds an even-parity bit to
// every frame and a PARITY state to the receive FSM).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Register offsets on i_wb_addr
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEVEL  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS register bit indices
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAMING   = 3;
  localparam int STAT_PARITY    = 4;

  // Serial frame length in bit-times: start + 8 data + [parity] + stop
`ifdef WB_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef WB_UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding received bytes.
//   clk, rst_n   : clock, asynchronous active-low clear of pointers/occupancy
//   i_push       : write i_wr_data (accepted when not full, or when full and
//                  a pop happens in the same cycle)
//   i_pop        : drop the head entry (ignored when empty)
//   o_rd_data    : current head entry (valid when o_empty is low)
//   o_full       : occupancy == DEPTH
//   o_empty      : occupancy == 0
//   o_level      : occupancy, 0..DEPTH
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_wr_data,
  input  logic          i_pop,
  output logic [7:0]    o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          wr_en;
  logic          rd_en;

  assign o_full  = (count_q == LW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_level = count_q;

  // A full FIFO can still take a byte when the head leaves in the same cycle
  assign wr_en = i_push & (~o_full | i_pop);
  assign rd_en = i_pop & ~o_empty;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q,
  // so stale contents are never visible and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];

endmodule : uart_rx_fifo

// File: rtl/wb_uart_rx.sv
// -----------------------------------------------------------------------------
// wb_uart_rx
// Wishbone-responder UART receiver. Deserialises 8N1 frames (8E1 with the
// parity option) from i_uart_rx into an RX FIFO and exposes RXDATA / STATUS /
// LEVEL registers. Outputs are zero when not acknowledging so several
// responders can be OR-combined.
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4)
//   FIFO_DEPTH   : RX FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_uart_rx    : serial line, idle high, asynchronous to clk
//   i_wb_cyc/stb/we/addr/data : Wishbone request (stb pre-gated by decode)
//   o_wb_ack     : one-cycle acknowledge, one cycle after each strobe
//   o_wb_stl     : always 0
//   o_wb_data    : registered read data, 0 when o_wb_ack is low
//   o_irq        : high while the FIFO holds data
// Optional feature macro: WB_UART_RX_PARITY_EN (even parity bit per frame,
// STATUS bit4 parity error).
// -----------------------------------------------------------------------------
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [1:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stl,
  output logic [7:0] o_wb_data,
  output logic       o_irq
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  // First wait lands in the middle of the start bit, later waits are whole bits
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Line synchroniser (idles high so reset does not look like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM and datapath
  // ---------------------------------------------------------------------------
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             cnt_done;
  logic             rx_push;
  logic             frame_err_evt;
  logic             parity_err_evt;
`ifdef WB_UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif

  assign cnt_done = (cnt_q == '0);

  // State register (datapath registers share the same reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef WB_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef WB_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!rx_sync_q) state_d = ST_START;
      // A start bit that is high again at mid-bit was a glitch
      ST_START:     if (cnt_done) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
`ifdef WB_UART_RX_PARITY_EN
      ST_DATA:      if (cnt_done && bit_idx_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY:    if (cnt_done) state_d = ST_STOP;
`else
      ST_DATA:      if (cnt_done && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
      ST_STOP:      if (cnt_done) state_d = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
      // Hold off until the line returns high, so a break yields one error only
      ST_WAIT_HIGH: if (rx_sync_q) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_push        = 1'b0;
    frame_err_evt  = 1'b0;
    parity_err_evt = 1'b0;
`ifdef WB_UART_RX_PARITY_EN
    par_bad_d      = par_bad_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = CNT_HALF;
        bit_idx_d = '0;
`ifdef WB_UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      ST_START: begin
        cnt_d = cnt_done ? CNT_FULL : cnt_q - CNT_W'(1);
      end
      ST_DATA: begin
        if (cnt_done) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = CNT_FULL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef WB_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_done) begin
          par_bad_d      = (rx_sync_q != even_parity(shift_q));
          parity_err_evt = par_bad_d;
          cnt_d          = CNT_FULL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_done) begin
          if (rx_sync_q) begin
`ifdef WB_UART_RX_PARITY_EN
            rx_push = ~par_bad_q;
`else
            rx_push = 1'b1;
`endif
          end else begin
            frame_err_evt = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (rx_push),
    .i_wr_data (shift_q),
    .i_pop     (fifo_pop),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Wishbone register interface
  // ---------------------------------------------------------------------------
  logic       wb_req, rd_req, wr_req, status_clr;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] status;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;
  logic       overrun_evt;
  logic       unused_wdata;

  assign wb_req     = i_wb_cyc & i_wb_stb;
  assign rd_req     = wb_req & ~i_wb_we;
  assign wr_req     = wb_req & i_wb_we;
  assign status_clr = wr_req & (i_wb_addr == REG_STATUS);

  // Pops commit at the strobe edge regardless of what happens to the ack
  assign fifo_pop    = rd_req & (i_wb_addr == REG_RXDATA) & ~fifo_empty;
  assign overrun_evt = rx_push & fifo_full & ~fifo_pop;

  // Only the write-one-to-clear bits of i_wb_data have any effect
  assign unused_wdata = ^{i_wb_data[7:5], i_wb_data[4], i_wb_data[1:0]};

  always_comb begin
    status                 = '0;
    status[STAT_NOT_EMPTY] = ~fifo_empty;
    status[STAT_FULL]      = fifo_full;
    status[STAT_OVERRUN]   = ovr_q;
    status[STAT_FRAMING]   = ferr_q;
    status[STAT_PARITY]    = perr_q;
  end

  always_comb begin
    ack_d   = wb_req;
    rdata_d = '0;
    if (rd_req) begin
      unique case (i_wb_addr)
        REG_RXDATA: rdata_d = fifo_empty ? 8'h00 : fifo_rd_data;
        REG_STATUS: rdata_d = status;
        REG_LEVEL:  rdata_d = 8'(fifo_level);
        default:    rdata_d = '0;
      endcase
    end

    // A new event in the same cycle as its clear keeps the flag set
    ovr_d  = (ovr_q  & ~(status_clr & i_wb_data[STAT_OVERRUN])) | overrun_evt;
    ferr_d = (ferr_q & ~(status_clr & i_wb_data[STAT_FRAMING])) | frame_err_evt;
`ifdef WB_UART_RX_PARITY_EN
    perr_d = (perr_q & ~(status_clr & i_wb_data[STAT_PARITY])) | parity_err_evt;
`else
    perr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // An initiator that drops cyc in the ack cycle has abandoned the transfer
  assign o_wb_ack  = ack_q & i_wb_cyc;
  assign o_wb_data = o_wb_ack ? rdata_q : 8'h00;
  assign o_wb_stl  = 1'b0;
  assign o_irq     = ~fifo_empty;

endmodule : wb_uart_rx
